data_bus_arbiter: RTL and testbench

- Parametrised, registered arbiter between one host stream port and NUM_CH accelerator channel FIFO pairs (FFT/FIR/IIR and later additions).
- Per channel: a "to" FIFO (host → accelerator) and a "from" FIFO (accelerator → host).
- Selects a channel, picks a direction from the FIFO status flags (drain-first), and moves bursts of up to MAX_BURST words.
- Supports a fixed-channel mode and a round-robin mode.

---
 rtl/data_bus_arbiter.sv | 188 ++++++++++++++++++
 tb/tb_data_bus_arbiter.sv | 398 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_bus_arbiter.sv
// data_bus_arbiter: registered arbiter between one host stream port and
// NUM_CH accelerator to/from FIFO pairs, drain-first, bounded bursts.
module data_bus_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_CH     = 3,
    parameter int CH_W       = 2,
    parameter int MAX_BURST  = 8,
    parameter int BURST_W    = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         cfg_mode,
    input  logic [CH_W-1:0]              cfg_ch,
    input  logic [NUM_CH-1:0]            ch_enable,
    input  logic                         host_in_valid,
    input  logic [DATA_WIDTH-1:0]        host_in_data,
    output logic                         host_in_ready,
    output logic                         host_out_valid,
    output logic [DATA_WIDTH-1:0]        host_out_data,
    input  logic                         host_out_ready,
    input  logic [NUM_CH-1:0]            to_full,
    output logic [NUM_CH-1:0]            to_push,
    output logic [DATA_WIDTH-1:0]        to_data,
    input  logic [NUM_CH-1:0]            from_empty,
    output logic [NUM_CH-1:0]            from_pop,
    input  logic [NUM_CH*DATA_WIDTH-1:0] from_data,
    output logic [CH_W-1:0]              grant_ch,
    output logic                         busy,
    output logic                         xfer_dir
);

    typedef enum logic [1:0] {
        ARB,
        XFER_TO,
        XFER_FROM
    } state_t;

    state_t                state_q, state_d;
    logic [CH_W-1:0]       grant_q, grant_d;
    logic [CH_W-1:0]       rr_q, rr_d;
    logic [BURST_W-1:0]    burst_q, burst_d;
    logic                  out_valid_q, out_valid_d;
    logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
    logic                  busy_q, busy_d;
    logic                  dir_q, dir_d;

    logic [CH_W-1:0]       cand;
    logic                  cand_en;
    logic                  cand_empty;
    logic                  cand_full;
    logic                  g_full;
    logic                  g_empty;
    logic [DATA_WIDTH-1:0] g_data;
    logic                  push;
    logic                  pop;
    logic                  last;

    function automatic logic [CH_W-1:0] next_ch(input logic [CH_W-1:0] ch);
        return (ch >= CH_W'(NUM_CH - 1)) ? '0 : ch + 1'b1;
    endfunction

    // Out-of-range indices never match, so they read as disabled/empty/full.
    always_comb begin
        cand       = cfg_mode ? rr_q : cfg_ch;
        cand_en    = 1'b0;
        cand_empty = 1'b1;
        cand_full  = 1'b1;
        g_full     = 1'b1;
        g_empty    = 1'b1;
        g_data     = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (cand == CH_W'(c)) begin
                cand_en    = ch_enable[c];
                cand_empty = from_empty[c];
                cand_full  = to_full[c];
            end
            if (grant_q == CH_W'(c)) begin
                g_full  = to_full[c];
                g_empty = from_empty[c];
                g_data  = from_data[c*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_comb begin
        host_in_ready = rst_n && (state_q == XFER_TO) && !g_full;
        push          = host_in_ready && host_in_valid;
        pop           = rst_n && (state_q == XFER_FROM) && !g_empty
                        && (!out_valid_q || host_out_ready);
        last          = (burst_q == BURST_W'(MAX_BURST - 1));
        to_push       = '0;
        from_pop      = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (grant_q == CH_W'(c)) begin
                to_push[c]  = push;
                from_pop[c] = pop;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        rr_d        = rr_q;
        burst_d     = burst_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;

        // The output register holds its word until the host takes it.
        if (host_out_ready) begin
            out_valid_d = 1'b0;
        end
        if (pop) begin
            out_valid_d = 1'b1;
            out_data_d  = g_data;
        end

        unique case (state_q)
            ARB: begin
                if (cand_en && !cand_empty) begin
                    state_d = XFER_FROM;
                    grant_d = cand;
                    burst_d = '0;
                end else if (cand_en && !cand_full && host_in_valid) begin
                    state_d = XFER_TO;
                    grant_d = cand;
                    burst_d = '0;
                end else if (cfg_mode) begin
                    rr_d = next_ch(rr_q);
                end
            end
            XFER_TO: begin
                if (push) begin
                    burst_d = burst_q + 1'b1;
                end
                if ((push && last) || !host_in_valid || g_full) begin
                    state_d = ARB;
                    rr_d    = next_ch(grant_q);
                end
            end
            XFER_FROM: begin
                if (pop) begin
                    burst_d = burst_q + 1'b1;
                end
                if ((pop && last) || g_empty) begin
                    state_d = ARB;
                    rr_d    = next_ch(grant_q);
                end
            end
            default: begin
                state_d = ARB;
            end
        endcase

        busy_d = (state_d != ARB);
        dir_d  = (state_d == XFER_FROM);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ARB;
            grant_q     <= '0;
            rr_q        <= '0;
            burst_q     <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            busy_q      <= 1'b0;
            dir_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            rr_q        <= rr_d;
            burst_q     <= burst_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            busy_q      <= busy_d;
            dir_q       <= dir_d;
        end
    end

    assign to_data        = host_in_data;
    assign host_out_valid = out_valid_q;
    assign host_out_data  = out_data_q;
    assign grant_ch       = grant_q;
    assign busy           = busy_q;
    assign xfer_dir       = dir_q;

endmodule

// File: tb/tb_data_bus_arbiter.sv
// tb_data_bus_arbiter: directed bench with FIFO models, an output
// scoreboard and an expected burst log for data_bus_arbiter.
module tb_data_bus_arbiter;

    localparam int DW  = 32;
    localparam int NCH = 3;
    localparam int CW  = 2;
    localparam int MB  = 8;
    localparam int BW  = 4;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            cfg_mode;
    logic [CW-1:0]   cfg_ch;
    logic [NCH-1:0]  ch_enable;
    logic            host_in_valid;
    logic [DW-1:0]   host_in_data;
    logic            host_in_ready;
    logic            host_out_valid;
    logic [DW-1:0]   host_out_data;
    logic            host_out_ready;
    logic [NCH-1:0]  to_full;
    logic [NCH-1:0]  to_push;
    logic [DW-1:0]   to_data;
    logic [NCH-1:0]  from_empty;
    logic [NCH-1:0]  from_pop;
    logic [NCH*DW-1:0] from_data;
    logic [CW-1:0]   grant_ch;
    logic            busy;
    logic            xfer_dir;

    always #5 clk = ~clk;

    data_bus_arbiter #(
        .DATA_WIDTH(DW),
        .NUM_CH    (NCH),
        .CH_W      (CW),
        .MAX_BURST (MB),
        .BURST_W   (BW)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .cfg_mode      (cfg_mode),
        .cfg_ch        (cfg_ch),
        .ch_enable     (ch_enable),
        .host_in_valid (host_in_valid),
        .host_in_data  (host_in_data),
        .host_in_ready (host_in_ready),
        .host_out_valid(host_out_valid),
        .host_out_data (host_out_data),
        .host_out_ready(host_out_ready),
        .to_full       (to_full),
        .to_push       (to_push),
        .to_data       (to_data),
        .from_empty    (from_empty),
        .from_pop      (from_pop),
        .from_data     (from_data),
        .grant_ch      (grant_ch),
        .busy          (busy),
        .xfer_dir      (xfer_dir)
    );

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] fq [NCH][$];
    logic [DW-1:0] tq [NCH][$];
    int            tcap [NCH];
    logic [DW-1:0] hq [$];
    logic          hin_en;
    logic [DW-1:0] sb [$];
    logic [15:0]   exp_b [$];
    logic [15:0]   got_b [$];
    int            cnt;
    logic [CW-1:0] cur_ch;
    logic          cur_dir;
    int            nout;
    logic          inv_on;
    logic          seen1;

    task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive();
        for (int c = 0; c < NCH; c++) begin
            from_empty[c] = (fq[c].size() == 0);
            from_data[c*DW +: DW] = (fq[c].size() > 0) ? fq[c][0] : '0;
            to_full[c] = (tq[c].size() >= tcap[c]);
        end
        host_in_valid = hin_en && (hq.size() > 0);
        host_in_data  = (hq.size() > 0) ? hq[0] : '0;
    endtask

    task automatic tick();
        logic [NCH-1:0] p;
        logic [NCH-1:0] s;
        logic           hin;
        logic           hout;
        logic           hr;
        logic           b;
        logic           d;
        logic           rs;
        logic [CW-1:0]  g;
        logic [DW-1:0]  od;
        logic [DW-1:0]  id;
        @(posedge clk);
        p    = from_pop;
        s    = to_push;
        hr   = host_in_ready;
        hin  = host_in_valid & host_in_ready;
        hout = host_out_valid & host_out_ready;
        od   = host_out_data;
        id   = to_data;
        b    = busy;
        d    = xfer_dir;
        g    = grant_ch;
        rs   = rst_n;
        #1;
        if (inv_on) begin
            check("pop_onehot", $onehot0(p), 1);
            check("push_onehot", $onehot0(s), 1);
            check("pop_push_excl", (|p) && (|s), 0);
            check("push_vs_host_hs", |s, hin);
            check("to_data_bcast", id, host_in_data);
            if (!(b === 1'b1 && d === 1'b0))
                check("ready_outside_to", hr, 0);
        end
        for (int c = 0; c < NCH; c++) begin
            if (p[c] === 1'b1) void'(fq[c].pop_front());
            if (s[c] === 1'b1) tq[c].push_back(id);
        end
        if (hin === 1'b1) void'(hq.pop_front());
        if (hout === 1'b1 && rs === 1'b1) begin
            nout++;
            check("out_expected", sb.size() != 0, 1);
            if (sb.size() != 0) check("host_out_data", od, sb.pop_front());
        end
        cnt += $countones(p) + $countones(s);
        if (b === 1'b1) begin
            cur_ch  = g;
            cur_dir = d;
            if (g == 2'd1) seen1 = 1'b1;
        end
        if (b === 1'b1 && busy !== 1'b1) begin
            got_b.push_back({4'(cur_ch), 4'(cur_dir), 8'(cnt)});
            cnt = 0;
        end
        drive();
    endtask

    task automatic compare_logs(string tag);
        int n;
        check({tag, "_bursts"}, got_b.size(), exp_b.size());
        n = (got_b.size() < exp_b.size()) ? got_b.size() : exp_b.size();
        for (int i = 0; i < n; i++)
            check({tag, "_burst"}, got_b[i], exp_b[i]);
        check({tag, "_sb_left"}, sb.size(), 0);
        got_b.delete();
        exp_b.delete();
        sb.delete();
        cnt = 0;
    endtask

    task automatic clear_env();
        for (int c = 0; c < NCH; c++) begin
            fq[c].delete();
            tq[c].delete();
            tcap[c] = 64;
        end
        hq.delete();
        drive();
    endtask

    function automatic logic [15:0] bl(int ch, int dir, int len);
        return {4'(ch), 4'(dir), 8'(len)};
    endfunction

    initial begin
        logic [DW-1:0] w;
        logic [DW-1:0] hold;
        int            guard;
        int            sz;

        inv_on         = 1'b0;
        seen1          = 1'b0;
        cnt            = 0;
        nout           = 0;
        cur_ch         = '0;
        cur_dir        = 1'b0;
        rst_n          = 1'b0;
        cfg_mode       = 1'b0;
        cfg_ch         = 2'd0;
        ch_enable      = 3'b111;
        host_out_ready = 1'b1;
        hin_en         = 1'b1;
        clear_env();

        // Reset with every "from" FIFO non-empty
        fq[0].push_back(32'hC0);
        fq[0].push_back(32'hC1);
        fq[1].push_back(32'hD0);
        fq[2].push_back(32'hE0);
        drive();
        sb.push_back(32'hC0);
        sb.push_back(32'hC1);
        exp_b.push_back(bl(0, 1, 2));
        repeat (3) tick();
        inv_on = 1'b1;
        check("rst_out_valid", host_out_valid, 0);
        check("rst_out_data", host_out_data, 0);
        check("rst_grant", grant_ch, 0);
        check("rst_busy", busy, 0);
        check("rst_dir", xfer_dir, 0);
        check("rst_to_push", to_push, 0);
        check("rst_from_pop", from_pop, 0);
        check("rst_in_ready", host_in_ready, 0);
        rst_n = 1'b1;
        #1;
        check("first_cycle_no_pop", from_pop, 0);
        tick();
        check("second_cycle_pop", from_pop, 3'b001);
        check("second_cycle_busy", busy, 1);
        check("second_cycle_dir", xfer_dir, 1);
        repeat (10) tick();
        compare_logs("reset");
        ch_enable = 3'b000;
        clear_env();
        tick();

        // Drain has priority over a pending host write
        cfg_ch = 2'd1;
        fq[1].push_back(32'hA1);
        fq[1].push_back(32'hA2);
        fq[1].push_back(32'hA3);
        hq.push_back(32'hB1);
        hq.push_back(32'hB2);
        sb.push_back(32'hA1);
        sb.push_back(32'hA2);
        sb.push_back(32'hA3);
        exp_b.push_back(bl(1, 1, 3));
        exp_b.push_back(bl(1, 0, 2));
        drive();
        ch_enable = 3'b111;
        repeat (15) tick();
        check("drain_to_count", tq[1].size(), 2);
        if (tq[1].size() == 2) begin
            check("drain_to_w0", tq[1][0], 32'hB1);
            check("drain_to_w1", tq[1][1], 32'hB2);
        end
        compare_logs("drain");
        ch_enable = 3'b000;
        clear_env();
        tick();

        // Burst limit: 20 host words split 8/8/4
        cfg_ch = 2'd2;
        for (int i = 0; i < 20; i++) hq.push_back(32'h100 + i);
        exp_b.push_back(bl(2, 0, 8));
        exp_b.push_back(bl(2, 0, 8));
        exp_b.push_back(bl(2, 0, 4));
        drive();
        ch_enable = 3'b111;
        repeat (40) tick();
        check("burst_to_count", tq[2].size(), 20);
        for (int i = 0; i < 20 && i < tq[2].size(); i++)
            check("burst_to_word", tq[2][i], 32'h100 + i);
        compare_logs("burst");
        ch_enable = 3'b000;
        clear_env();
        tick();

        // Host backpressure mid-burst
        cfg_ch = 2'd0;
        for (int i = 0; i < 6; i++) begin
            fq[0].push_back(32'h200 + i);
            sb.push_back(32'h200 + i);
        end
        exp_b.push_back(bl(0, 1, 6));
        drive();
        ch_enable = 3'b111;
        nout  = 0;
        guard = 0;
        while (nout < 2 && guard < 20) begin
            tick();
            guard++;
        end
        check("bp_started", nout >= 2, 1);
        host_out_ready = 1'b0;
        hold = host_out_data;
        #1;
        check("bp_pop_now", from_pop, 0);
        for (int k = 0; k < 5; k++) begin
            tick();
            check("bp_pop", from_pop, 0);
            check("bp_valid", host_out_valid, 1);
            check("bp_data", host_out_data, hold);
        end
        host_out_ready = 1'b1;
        repeat (15) tick();
        compare_logs("backpressure");
        ch_enable = 3'b000;
        clear_env();
        tick();

        // Round-robin fairness from a fresh pointer
        rst_n = 1'b0;
        tick();
        rst_n     = 1'b1;
        cfg_mode  = 1'b1;
        for (int c = 0; c < NCH; c++)
            for (int i = 0; i < 16; i++)
                fq[c].push_back(((c + 1) << 8) | i);
        for (int r = 0; r < 2; r++)
            for (int c = 0; c < NCH; c++) begin
                exp_b.push_back(bl(c, 1, 8));
                for (int i = 0; i < 8; i++) begin
                    w = ((c + 1) << 8) | (r * 8 + i);
                    sb.push_back(w);
                end
            end
        drive();
        ch_enable = 3'b111;
        repeat (100) tick();
        compare_logs("round_robin");
        ch_enable = 3'b000;
        clear_env();
        tick();

        // Masked channel and "to" FIFO filling after two pushes
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        seen1 = 1'b0;
        for (int i = 0; i < 3; i++) fq[1].push_back(32'h400 + i);
        for (int i = 0; i < 5; i++) hq.push_back(32'h300 + i);
        tcap[0] = 2;
        tcap[2] = 0;
        exp_b.push_back(bl(0, 0, 2));
        drive();
        ch_enable = 3'b101;
        repeat (40) tick();
        check("mask_ch1_granted", seen1, 0);
        check("mask_ch1_left", fq[1].size(), 3);
        check("full_to_count", tq[0].size(), 2);
        if (tq[0].size() == 2) begin
            check("full_to_w0", tq[0][0], 32'h300);
            check("full_to_w1", tq[0][1], 32'h301);
        end
        compare_logs("mask");
        ch_enable = 3'b000;
        clear_env();
        tick();

        // Reset in the middle of a drain burst
        cfg_mode = 1'b0;
        cfg_ch   = 2'd0;
        for (int i = 0; i < 8; i++) begin
            fq[0].push_back(32'h500 + i);
            sb.push_back(32'h500 + i);
        end
        drive();
        ch_enable = 3'b111;
        nout  = 0;
        guard = 0;
        while (nout < 2 && guard < 20) begin
            tick();
            guard++;
        end
        check("midrst_started", nout >= 2, 1);
        check("midrst_busy_before", busy, 1);
        rst_n = 1'b0;
        #1;
        check("midrst_no_pop", from_pop, 0);
        check("midrst_no_ready", host_in_ready, 0);
        sz = fq[0].size();
        tick();
        check("midrst_fifo_kept", fq[0].size(), sz);
        check("midrst_busy", busy, 0);
        check("midrst_out_valid", host_out_valid, 0);
        check("midrst_out_data", host_out_data, 0);
        check("midrst_grant", grant_ch, 0);
        ch_enable = 3'b000;
        rst_n     = 1'b1;
        sb.delete();
        exp_b.delete();
        got_b.delete();
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
